// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: access size, request/write-back
// control packets and the M-stage FSM state.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2
   } mem_size_t;

   typedef struct packed {
      logic      val;
      logic      we;
      mem_size_t size;
      logic      is_unsigned;
   } dmem_req_ctrl_t;

   typedef struct packed {
      logic       wen;
      logic [4:0] rd;
   } rf_wb_ctrl_t;

   typedef enum logic {
      MEM_IDLE      = 1'b0,
      MEM_WAIT_RESP = 1'b1
   } mem_fsm_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the M stage (master) and memory.
interface mem_stage_if #(
   parameter int unsigned N_BITS = 32
);
   logic              dmem_req_val;
   logic              dmem_req_rdy;
   logic [N_BITS-1:0] dmem_req_addr;
   logic              dmem_req_we;
   logic [3:0]        dmem_req_wstrb;
   logic [N_BITS-1:0] dmem_req_wdata;
   logic              dmem_resp_val;
   logic [N_BITS-1:0] dmem_resp_rdata;

   modport master (
      output dmem_req_val, dmem_req_addr, dmem_req_we, dmem_req_wstrb, dmem_req_wdata,
      input  dmem_req_rdy, dmem_resp_val, dmem_resp_rdata
   );

   modport slave (
      input  dmem_req_val, dmem_req_addr, dmem_req_we, dmem_req_wstrb, dmem_req_wdata,
      output dmem_req_rdy, dmem_resp_val, dmem_resp_rdata
   );
endinterface

// File: rtl/dl_reg_en_rst.sv
// Generic pipeline register with enable and asynchronous active-low clear.
module dl_reg_en_rst #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end
endmodule

// File: rtl/lsu_align.sv
// Combinational load/store alignment: store lane strobes and replication,
// load extract with sign/zero extension, and the misalignment check.
module lsu_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  offset_i,
   input  mem_size_t   size_i,
   input  logic        is_unsigned_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o
);
   logic [31:0] shifted;

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      wstrb_o      = 4'hF;
      wdata_o      = store_data_i;
      load_data_o  = shifted;
      misaligned_o = 1'b0;
      case (size_i)
         MEM_B: begin
            wstrb_o     = 4'b0001 << offset_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = is_unsigned_i ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
         end
         MEM_H: begin
            wstrb_o      = 4'b0011 << offset_i;
            wdata_o      = {2{store_data_i[15:0]}};
            load_data_o  = is_unsigned_i ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            misaligned_o = offset_i[0];
         end
         default: begin
            misaligned_o = |offset_i;
         end
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers the E-stage outputs, issues one data-memory request
// per memory instruction, waits for load data and drives write-back.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned N_BITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_BITS-1:0] alu_result_in,
   input  logic [N_BITS-1:0] store_data_in,
   input  dmem_req_ctrl_t    dmem_req_ctrl_pkt_in,
   input  rf_wb_ctrl_t       rf_wb_ctrl_pkt_in,
   output logic              stall,
   mem_stage_if.master       dmem,
   output logic [N_BITS-1:0] wb_data,
   output rf_wb_ctrl_t       rf_wb_ctrl_pkt_out,
   output logic              misalign_exc
);
   localparam int unsigned M_W = 2 * N_BITS + $bits(dmem_req_ctrl_t) + $bits(rf_wb_ctrl_t);

   logic [M_W-1:0]    m_d, m_q;
   logic [N_BITS-1:0] alu_q, sd_q;
   dmem_req_ctrl_t    req_q;
   rf_wb_ctrl_t       wb_q;
   mem_fsm_state_t    state_d, state_q;

   logic [3:0]  lsu_wstrb;
   logic [31:0] lsu_wdata, lsu_load_data;
   logic        lsu_misaligned, misaligned, mem_op, done;

   assign m_d = {alu_result_in, store_data_in, dmem_req_ctrl_pkt_in, rf_wb_ctrl_pkt_in};
   assign {alu_q, sd_q, req_q, wb_q} = m_q;

   dl_reg_en_rst #(.W(M_W)) u_m_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (~stall),
      .d_i   (m_d),
      .q_o   (m_q)
   );

   lsu_align u_lsu_align (
      .offset_i      (alu_q[1:0]),
      .size_i        (req_q.size),
      .is_unsigned_i (req_q.is_unsigned),
      .store_data_i  (sd_q),
      .rdata_i       (dmem.dmem_resp_rdata),
      .wstrb_o       (lsu_wstrb),
      .wdata_o       (lsu_wdata),
      .load_data_o   (lsu_load_data),
      .misaligned_o  (lsu_misaligned)
   );

   assign misaligned = req_q.val & lsu_misaligned;
   assign mem_op     = req_q.val & ~misaligned;

   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_IDLE:
            if (dmem.dmem_req_val && dmem.dmem_req_rdy && !req_q.we) state_d = MEM_WAIT_RESP;
         MEM_WAIT_RESP:
            if (dmem.dmem_resp_val) state_d = MEM_IDLE;
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= MEM_IDLE;
      else        state_q <= state_d;
   end

   // Request fields come only from M registers and state, never from rdy.
   assign dmem.dmem_req_val   = (state_q == MEM_IDLE) & mem_op;
   assign dmem.dmem_req_addr  = {alu_q[N_BITS-1:2], 2'b00};
   assign dmem.dmem_req_we    = req_q.we;
   assign dmem.dmem_req_wstrb = req_q.we ? lsu_wstrb : 4'b0000;
   assign dmem.dmem_req_wdata = lsu_wdata;

   assign done  = ((state_q == MEM_IDLE) & dmem.dmem_req_val & dmem.dmem_req_rdy & req_q.we)
                | ((state_q == MEM_WAIT_RESP) & dmem.dmem_resp_val);
   assign stall = mem_op & ~done;

   assign wb_data      = (req_q.val & ~req_q.we) ? lsu_load_data : alu_q;
   assign misalign_exc = misaligned;

   always_comb begin
      rf_wb_ctrl_pkt_out     = wb_q;
      rf_wb_ctrl_pkt_out.wen = wb_q.wen & ~stall & ~misaligned;
   end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected requests,
// write-backs and exceptions; a negedge monitor pops and compares them.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [31:0]    alu_in, sd_in, wb_data;
   dmem_req_ctrl_t ctrl_in;
   rf_wb_ctrl_t    wb_in, wb_out;
   logic           stall, misalign_exc;

   mem_stage_if #(.N_BITS(32)) dmem_bus ();

   mem_stage #(.N_BITS(32)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .alu_result_in        (alu_in),
      .store_data_in        (sd_in),
      .dmem_req_ctrl_pkt_in (ctrl_in),
      .rf_wb_ctrl_pkt_in    (wb_in),
      .stall                (stall),
      .dmem                 (dmem_bus),
      .wb_data              (wb_data),
      .rf_wb_ctrl_pkt_out   (wb_out),
      .misalign_exc         (misalign_exc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   req_exp_t   req_exp_q[$];
   wb_exp_t    wb_exp_q[$];
   logic [4:0] exc_exp_q[$];
   int checks = 0;
   int failures = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endfunction

   function automatic dmem_req_ctrl_t mk_ctrl(logic v, logic we, mem_size_t sz, logic u);
      dmem_req_ctrl_t c;
      c.val = v; c.we = we; c.size = sz; c.is_unsigned = u;
      return c;
   endfunction

   function automatic rf_wb_ctrl_t mk_wb(logic wen, logic [4:0] rd);
      rf_wb_ctrl_t w;
      w.wen = wen; w.rd = rd;
      return w;
   endfunction

   // Monitor: every accepted request, write-back and exception must be expected.
   always @(negedge clk) begin
      req_exp_t   re;
      wb_exp_t    we_e;
      logic [4:0] xr;
      if (rst_n) begin
         if (dmem_bus.dmem_req_val && dmem_bus.dmem_req_rdy) begin
            if (req_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL req_unexpected actual_addr=0x%08h required=none", dmem_bus.dmem_req_addr);
            end else begin
               re = req_exp_q.pop_front();
               chk("req_addr", dmem_bus.dmem_req_addr, re.addr);
               chk("req_we", 32'(dmem_bus.dmem_req_we), 32'(re.we));
               chk("req_wstrb", 32'(dmem_bus.dmem_req_wstrb), 32'(re.wstrb));
               chk("req_wdata", dmem_bus.dmem_req_wdata, re.wdata);
            end
         end
         if (wb_out.wen) begin
            if (wb_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL wb_unexpected actual_rd=%0d data=0x%08h required=none", wb_out.rd, wb_data);
            end else begin
               we_e = wb_exp_q.pop_front();
               chk("wb_rd", 32'(wb_out.rd), 32'(we_e.rd));
               chk("wb_data", wb_data, we_e.data);
            end
         end
         if (misalign_exc) begin
            if (exc_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL exc_unexpected actual_rd=%0d required=none", wb_out.rd);
            end else begin
               xr = exc_exp_q.pop_front();
               chk("exc_rd", 32'(wb_out.rd), 32'(xr));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      alu_in = '0; sd_in = '0; ctrl_in = '0; wb_in = '0;
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] sd,
                        input dmem_req_ctrl_t c, input rf_wb_ctrl_t w);
      alu_in = alu; sd_in = sd; ctrl_in = c; wb_in = w;
   endtask

   task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] s,
                           input logic [31:0] d);
      req_exp_t r;
      r.addr = a; r.we = we; r.wstrb = s; r.wdata = d;
      req_exp_q.push_back(r);
   endtask

   task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
      wb_exp_t w;
      w.rd = rd; w.data = d;
      wb_exp_q.push_back(w);
   endtask

   task automatic do_load(input logic [31:0] addr, input mem_size_t sz, input logic u,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int unsigned waits, input logic [31:0] exp);
      drive(addr, 32'h0, mk_ctrl(1'b1, 1'b0, sz, u), mk_wb(1'b1, rd));
      push_req({addr[31:2], 2'b00}, 1'b0, 4'h0, 32'h0);
      push_wb(rd, exp);
      step();
      bubble();
      chk("ld_accept_stall", 32'(stall), 32'd1);
      step();
      for (int unsigned i = 0; i < waits; i++) begin
         chk("ld_wait_stall", 32'(stall), 32'd1);
         chk("ld_wait_noreq", 32'(dmem_bus.dmem_req_val), 32'd0);
         step();
      end
      dmem_bus.dmem_resp_val   = 1'b1;
      dmem_bus.dmem_resp_rdata = rdata;
      #1;
      chk("ld_resp_stall", 32'(stall), 32'd0);
      step();
      dmem_bus.dmem_resp_val   = 1'b0;
      dmem_bus.dmem_resp_rdata = '0;
   endtask

   initial begin
      bubble();
      dmem_bus.dmem_req_rdy    = 1'b1;
      dmem_bus.dmem_resp_val   = 1'b0;
      dmem_bus.dmem_resp_rdata = '0;
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req_val", 32'(dmem_bus.dmem_req_val), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wen", 32'(wb_out.wen), 32'd0);
      step(); step();
      rst_n = 1'b1;

      // ALU op
      drive(32'h1234_5678, 32'hFFFF_FFFF, mk_ctrl(1'b0, 1'b0, MEM_W, 1'b0), mk_wb(1'b1, 5'd5));
      push_wb(5'd5, 32'h1234_5678);
      step(); bubble();
      chk("alu_stall", 32'(stall), 32'd0);
      chk("alu_noreq", 32'(dmem_bus.dmem_req_val), 32'd0);
      step();

      // sw with two cycles of back-pressure
      dmem_bus.dmem_req_rdy = 1'b0;
      drive(32'h100, 32'hDEAD_BEEF, mk_ctrl(1'b1, 1'b1, MEM_W, 1'b0), mk_wb(1'b0, 5'd0));
      push_req(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
      step(); bubble();
      for (int unsigned i = 0; i < 2; i++) begin
         chk("sw_val_held", 32'(dmem_bus.dmem_req_val), 32'd1);
         chk("sw_stall", 32'(stall), 32'd1);
         chk("sw_addr_held", dmem_bus.dmem_req_addr, 32'h100);
         chk("sw_wstrb_held", 32'(dmem_bus.dmem_req_wstrb), 32'hF);
         step();
      end
      dmem_bus.dmem_req_rdy = 1'b1;
      #1;
      chk("sw_val_c3", 32'(dmem_bus.dmem_req_val), 32'd1);
      chk("sw_stall_c3", 32'(stall), 32'd0);
      step();
      chk("sw_done_noreq", 32'(dmem_bus.dmem_req_val), 32'd0);

      // sh and sb lane placement
      drive(32'h102, 32'h0000_ABCD, mk_ctrl(1'b1, 1'b1, MEM_H, 1'b0), mk_wb(1'b0, 5'd0));
      push_req(32'h100, 1'b1, 4'b1100, 32'hABCD_ABCD);
      step(); bubble();
      chk("sh_stall", 32'(stall), 32'd0);
      step();
      drive(32'h101, 32'h0000_005A, mk_ctrl(1'b1, 1'b1, MEM_B, 1'b0), mk_wb(1'b0, 5'd0));
      push_req(32'h100, 1'b1, 4'b0010, 32'h5A5A_5A5A);
      step(); bubble(); step();

      // loads: extract and extend
      do_load(32'h103, MEM_B, 1'b0, 5'd7,  32'h80FF_0000, 1, 32'hFFFF_FF80);
      do_load(32'h103, MEM_B, 1'b1, 5'd8,  32'h80FF_0000, 0, 32'h0000_0080);
      do_load(32'h102, MEM_H, 1'b0, 5'd11, 32'h8001_1234, 0, 32'hFFFF_8001);
      do_load(32'h100, MEM_H, 1'b1, 5'd12, 32'h8001_1234, 0, 32'h0000_1234);
      do_load(32'h104, MEM_W, 1'b0, 5'd13, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

      // misaligned accesses
      drive(32'h101, 32'h0, mk_ctrl(1'b1, 1'b0, MEM_W, 1'b0), mk_wb(1'b1, 5'd9));
      exc_exp_q.push_back(5'd9);
      step(); bubble();
      chk("mis_lw_noreq", 32'(dmem_bus.dmem_req_val), 32'd0);
      chk("mis_lw_stall", 32'(stall), 32'd0);
      chk("mis_lw_exc", 32'(misalign_exc), 32'd1);
      chk("mis_lw_wen", 32'(wb_out.wen), 32'd0);
      step();
      chk("mis_lw_exc_once", 32'(misalign_exc), 32'd0);
      drive(32'h103, 32'h1234, mk_ctrl(1'b1, 1'b1, MEM_H, 1'b0), mk_wb(1'b0, 5'd14));
      exc_exp_q.push_back(5'd14);
      step(); bubble();
      chk("mis_sh_noreq", 32'(dmem_bus.dmem_req_val), 32'd0);
      chk("mis_sh_stall", 32'(stall), 32'd0);
      step();

      // reset while a load waits for its response
      drive(32'h200, 32'h0, mk_ctrl(1'b1, 1'b0, MEM_W, 1'b0), mk_wb(1'b1, 5'd10));
      push_req(32'h200, 1'b0, 4'h0, 32'h0);
      step(); bubble();
      chk("rl_accept_stall", 32'(stall), 32'd1);
      step();
      chk("rl_wait_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rl_rst_stall", 32'(stall), 32'd0);
      chk("rl_rst_req_val", 32'(dmem_bus.dmem_req_val), 32'd0);
      chk("rl_rst_wstrb", 32'(dmem_bus.dmem_req_wstrb), 32'd0);
      chk("rl_rst_wb_data", wb_data, 32'd0);
      chk("rl_rst_wen", 32'(wb_out.wen), 32'd0);
      chk("rl_rst_exc", 32'(misalign_exc), 32'd0);
      step();
      rst_n = 1'b1;
      dmem_bus.dmem_resp_val   = 1'b1;
      dmem_bus.dmem_resp_rdata = 32'h1111_1111;
      #1;
      chk("late_resp_stall", 32'(stall), 32'd0);
      chk("late_resp_wen", 32'(wb_out.wen), 32'd0);
      chk("late_resp_wb_data", wb_data, 32'd0);
      step();
      dmem_bus.dmem_resp_val = 1'b0;

      // pipeline still works after reset
      drive(32'hA5A5_0F0F, 32'h0, mk_ctrl(1'b0, 1'b0, MEM_W, 1'b0), mk_wb(1'b1, 5'd3));
      push_wb(5'd3, 32'hA5A5_0F0F);
      step(); bubble(); step(); step();

      chk("req_exp_left", 32'(req_exp_q.size()), 32'd0);
      chk("wb_exp_left", 32'(wb_exp_q.size()), 32'd0);
      chk("exc_exp_left", 32'(exc_exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
